// File: rtl/adder_pkg.sv
// Shared types and constants for the adder responder and its ALU.
package adder_pkg;

  // Default operand width.
  localparam int ADDER_WIDTH = 4;

  // Cycle counter width; covers a compute latency of 1..15 cycles.
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operation select, sampled at the request handshake.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/adder_alu.sv
// Combinational add/subtract unit. The result is one bit wider than the
// operands; the extra MSB is the carry for add and the borrow for subtract.
module adder_alu
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   c_o
);

  // Select add or subtract; the borrow is an explicit magnitude compare.
  always_comb begin
    c_o = '0;
    case (op_i)
      OP_ADD: c_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: begin
        c_o[WIDTH-1:0] = a_i - b_i;
        c_o[WIDTH]     = (a_i < b_i);
      end
    endcase
  end

endmodule

// File: rtl/adder_responder.sv
// Design-side responder for the adder interface. Accepts one operand pair,
// computes the result over CALC_CYCLES cycles, then holds it until the
// driver takes it. Counts completed transactions modulo 256.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The request side transfers when req_valid && req_ready;
// the response side when resp_valid && resp_ready. Both ready/valid outputs
// are decoded from the registered state only, so neither depends
// combinationally on any input. The FSM state is held in state_q.
module adder_responder
  import adder_pkg::*;
#(
  parameter int WIDTH       = ADDER_WIDTH,
  parameter int CALC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH:0]   c,
  output logic             busy,
  output logic [7:0]       txn_count
);

  // Counter load value: the counter runs CALC_CYCLES-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  op_t              op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH:0]   c_q,     c_d;
  logic [7:0]       txn_q,   txn_d;
  logic [WIDTH:0]   alu_res;

  // Single ALU, fed only from the captured operands so late input changes
  // cannot disturb an in-flight computation.
  adder_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .c_o  (alu_res)
  );

  // Next-state logic: capture on request, count down, present, retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    txn_d   = txn_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_t'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = CNT_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          c_d     = alu_res;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          txn_d   = txn_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      txn_q   <= txn_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign c          = c_q;
  assign txn_count  = txn_q;

endmodule

// File: doc/adder_responder.md
# adder_responder

Design-side responder for the adder interface: accepts an operand pair (a, b) and an operation from the testbench-side driver, computes the result over a fixed multi-cycle latency, and holds it until the driver accepts it. It sits behind the interface's DUT modport, opposite the stimulus/checker end. A small FSM and a transaction counter give it real sequential behaviour.

## Interface
Parameters:
- WIDTH, 4, operand width in bits.
- CALC_CYCLES, 2, compute latency in cycles; legal range 1..15.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- req_valid  input  1  driver presents a valid request.
- req_ready  output  1  responder can accept a request.
- op  input  1  0 = add, 1 = subtract; sampled at request handshake.
- a  input  WIDTH  first operand; sampled at request handshake.
- b  input  WIDTH  second operand; sampled at request handshake.
- resp_valid  output  1  result on c is valid.
- resp_ready  input  1  driver accepts the result.
- c  output  WIDTH+1  result; MSB is carry for add, borrow for subtract.
- busy  output  1  high in CALC or RESP.
- txn_count  output  8  completed transactions, wraps modulo 256.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, register op/a/b, load cycle counter with CALC_CYCLES-1, go to CALC.
- CALC: req_ready=0. If counter==0, register c and go to RESP; otherwise decrement.
- RESP: resp_valid=1, c held stable. On resp_ready, go to IDLE and increment txn_count.
- Add: c = zero-extended a + zero-extended b, WIDTH+1 bits; no truncation.
- Subtract: c[WIDTH-1:0] = (a - b) mod 2^WIDTH; c[WIDTH] = 1 iff a < b.
- req_valid is ignored outside IDLE; operands that change after the handshake have no effect.
- resp_ready is ignored outside RESP.
- txn_count wraps 255 -> 0 with no flag.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, c 0, busy 0, txn_count 0, cycle counter 0.
- req_ready = (state==IDLE); resp_valid = (state==RESP); busy = !IDLE. All three are decoded from registered state, with no combinational path from inputs.
- Request handshake at edge N: resp_valid rises after edge N+CALC_CYCLES.
- Response handshake at edge M: resp_valid falls and req_ready rises after edge M. The earliest next request handshake is edge M+1, so there is one dead cycle between transactions.
- Peak throughput is one transaction per CALC_CYCLES+2 cycles.
- rst has priority over everything and applies in any state. Mid-CALC or mid-RESP, the pending operation is discarded, c is cleared, and txn_count returns to 0 on the next edge. No response is emitted for the aborted request.
- rst together with a request or response handshake in the same cycle: the handshake is lost and the reset values apply.

## Structure
- Package adder_pkg holds: state_t enum {IDLE, CALC, RESP}; op_t enum {OP_ADD=0, OP_SUB=1}; default WIDTH constant.
- One natural sub-module, adder_alu: combinational, takes op/a/b and returns the WIDTH+1-bit result. It is instantiated once, fed from the registered operands.
- Top level holds the FSM, operand registers, cycle counter, result register and txn_count.

## Test plan
- Reset then idle: after rst held 2 cycles: req_ready=1, resp_valid=0, c=0, txn_count=0.
- Add with carry: a=4'b0011, b=4'b0001, op=0 -> c=5'd4, resp_valid after 2 cycles. Then a=15, b=1 -> c=5'b10000. txn_count=2 after both handshakes.
- Subtract with borrow: a=3, b=5, op=1 -> c=5'b11110. a=9, b=4 -> c=5'd5.
- Backpressure: hold resp_ready=0 for 10 cycles -> c stable, req_ready=0, and a request offered meanwhile is not accepted. Raising resp_ready -> one handshake, then req_ready=1 on the next cycle.
- Reset mid-operation: assert rst during CALC, and separately during RESP -> no resp_valid for the aborted request, txn_count=0, next request completes normally.
- Counter wrap: 256 back-to-back add transactions -> txn_count reads 0. With CALC_CYCLES=1, latency measures exactly 1 cycle.
